// File: rtl/key_sw_capture_if.sv
// Board-side switch/button bundle for key_sw_capture: raw inputs in, conditioned levels,
// pulses and the capture register out.
interface key_sw_capture_if;
  logic [17:0] SW;
  logic [3:0]  KEY;
  logic [17:0] sw_stable;
  logic [3:0]  key_down;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic [15:0] capture_val;
  logic        capture_valid;
  logic [7:0]  press_count;

  modport master (
    output SW, KEY,
    input  sw_stable, key_down, key_press, key_release,
    input  capture_val, capture_valid, press_count
  );

  modport slave (
    input  SW, KEY,
    output sw_stable, key_down, key_press, key_release,
    output capture_val, capture_valid, press_count
  );
endinterface

// File: rtl/key_sw_capture.sv
// DE2-115 input front end: 2-flop sync + per-channel debounce of SW[17:0]/KEY[3:0],
// registered press/release pulses and a KEY[0]-triggered capture of SW[15:0].
module key_sw_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input logic            CLOCK_50,
    input logic            RESET_N,
    key_sw_capture_if.slave bus
);

    localparam int unsigned     NCH  = 22;
    // Channel order is {KEY[3:0], SW[17:0]}; idle is switches down, buttons released.
    localparam logic [NCH-1:0]  IDLE = {4'hF, 18'h0};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]   sync1, sync2, q;
    logic [CNT_W-1:0] cnt [NCH];

    logic [17:0] sw_stable_r;
    logic [3:0]  key_down_r, key_press_r, key_release_r;
    logic [15:0] capture_val_r;
    logic        capture_valid_r;
    logic [7:0]  press_count_r;

    logic [3:0]  down_next, press_next, release_next;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= {bus.KEY, bus.SW};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            q <= IDLE;
            for (int unsigned i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (sync2[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    q[i]   <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Edges are detected against the registered level so pulse and level change together.
    always_comb begin
        down_next    = ~q[21:18];
        press_next   = down_next & ~key_down_r;
        release_next = ~down_next & key_down_r;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            sw_stable_r     <= '0;
            key_down_r      <= '0;
            key_press_r     <= '0;
            key_release_r   <= '0;
            capture_val_r   <= '0;
            capture_valid_r <= 1'b0;
            press_count_r   <= '0;
        end else begin
            sw_stable_r     <= q[17:0];
            key_down_r      <= down_next;
            key_press_r     <= press_next;
            key_release_r   <= release_next;
            capture_valid_r <= press_next[0] & ~press_next[1];
            // Clear on KEY[1] overrides a same-cycle capture; the count still advances.
            if (press_next[1])
                capture_val_r <= '0;
            else if (press_next[0])
                capture_val_r <= sw_stable_r[15:0];
            if (press_next[0])
                press_count_r <= press_count_r + 8'd1;
        end
    end

    assign bus.sw_stable     = sw_stable_r;
    assign bus.key_down      = key_down_r;
    assign bus.key_press     = key_press_r;
    assign bus.key_release   = key_release_r;
    assign bus.capture_val   = capture_val_r;
    assign bus.capture_valid = capture_valid_r;
    assign bus.press_count   = press_count_r;

endmodule
